// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads the sysid slave (ID word at address 0, timestamp at
// address 1) over Avalon-MM after a start pulse and flags any mismatch against
// the expected build values, or a slave that never releases waitrequest.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; results from the last check are held
// RD_ID   | read strobe on address 0, waiting for waitrequest to drop
// WAIT_ID | read accepted, counting down read latency for the ID word
// RD_TS   | read strobe on address 1, waiting for waitrequest to drop
// WAIT_TS | read accepted, counting down read latency for the timestamp
// DONE    | one-cycle done pulse; match flags valid
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1457919206,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        error,
  output logic [31:0] sysid_value,
  output logic [31:0] timestamp_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Down-counter reload values; terminal count is zero for both counters.
  localparam bit          LAT_ZERO = (READ_LATENCY == 0);
  localparam logic [2:0]  LAT_LOAD = 3'(READ_LATENCY - 1);
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [31:0] sysid_value_q, sysid_value_d;
  logic [31:0] timestamp_value_q, timestamp_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        error_q, error_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;

  // Sequencing, latency/timeout counting, capture and result evaluation.
  always_comb begin
    state_d           = state_q;
    lat_cnt_d         = lat_cnt_q;
    to_cnt_d          = to_cnt_q;
    sysid_value_d     = sysid_value_q;
    timestamp_value_d = timestamp_value_q;
    id_ok_d           = id_ok_q;
    ts_ok_d           = ts_ok_q;
    error_d           = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sysid_value_d     = '0;
          timestamp_value_d = '0;
          id_ok_d           = 1'b0;
          ts_ok_d           = 1'b0;
          error_d           = 1'b0;
          to_cnt_d          = TO_LOAD;
          state_d           = RD_ID;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          if (LAT_ZERO) begin
            sysid_value_d = avm_readdata;
            to_cnt_d      = TO_LOAD;
            state_d       = RD_TS;
          end else begin
            lat_cnt_d = LAT_LOAD;
            state_d   = WAIT_ID;
          end
        end else if (to_cnt_q == '0) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          to_cnt_d = to_cnt_q - 16'd1;
        end
      end
      WAIT_ID: begin
        if (lat_cnt_q == '0) begin
          sysid_value_d = avm_readdata;
          to_cnt_d      = TO_LOAD;
          state_d       = RD_TS;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          if (LAT_ZERO) begin
            timestamp_value_d = avm_readdata;
            id_ok_d           = (sysid_value_q == EXPECTED_ID);
            ts_ok_d           = (avm_readdata == EXPECTED_TIMESTAMP);
            state_d           = DONE;
          end else begin
            lat_cnt_d = LAT_LOAD;
            state_d   = WAIT_TS;
          end
        end else if (to_cnt_q == '0) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          to_cnt_d = to_cnt_q - 16'd1;
        end
      end
      WAIT_TS: begin
        if (lat_cnt_q == '0) begin
          timestamp_value_d = avm_readdata;
          id_ok_d           = (sysid_value_q == EXPECTED_ID);
          ts_ok_d           = (avm_readdata == EXPECTED_TIMESTAMP);
          state_d           = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus strobes are registered from the next state so they are glitch-free
    // and stay put for as long as the slave stalls.
    avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    avm_address_d = (state_d == RD_TS);
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      lat_cnt_q         <= '0;
      to_cnt_q          <= '0;
      sysid_value_q     <= '0;
      timestamp_value_q <= '0;
      id_ok_q           <= 1'b0;
      ts_ok_q           <= 1'b0;
      error_q           <= 1'b0;
      avm_read_q        <= 1'b0;
      avm_address_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      lat_cnt_q         <= lat_cnt_d;
      to_cnt_q          <= to_cnt_d;
      sysid_value_q     <= sysid_value_d;
      timestamp_value_q <= timestamp_value_d;
      id_ok_q           <= id_ok_d;
      ts_ok_q           <= ts_ok_d;
      error_q           <= error_d;
      avm_read_q        <= avm_read_d;
      avm_address_q     <= avm_address_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign error           = error_q;
  assign sysid_value     = sysid_value_q;
  assign timestamp_value = timestamp_value_q;
  assign avm_read        = avm_read_q;
  assign avm_address     = avm_address_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (read latency 0 and 2, timeout 4)
// run side by side against a small Avalon slave with programmable stalls.
// Expected results come from a cycle-arithmetic model of a check.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1457919206;
  localparam int          TMO    = 4;
  localparam int          L1     = 2;
  localparam int          WINDOW = 18;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy[2], done[2], id_ok[2], ts_ok[2], error[2];
  logic        avm_address[2], avm_read[2], avm_waitrequest[2];
  logic [31:0] sysid_value[2], timestamp_value[2], avm_readdata[2];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sysid_check_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
                     .READ_LATENCY(0), .TIMEOUT_CYCLES(TMO)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
    .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .error(error[0]),
    .sysid_value(sysid_value[0]), .timestamp_value(timestamp_value[0]),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]),
    .avm_waitrequest(avm_waitrequest[0]), .avm_readdata(avm_readdata[0]));

  sysid_check_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
                     .READ_LATENCY(L1), .TIMEOUT_CYCLES(TMO)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
    .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .error(error[1]),
    .sysid_value(sysid_value[1]), .timestamp_value(timestamp_value[1]),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]),
    .avm_waitrequest(avm_waitrequest[1]), .avm_readdata(avm_readdata[1]));

  // Slave model: word contents and per-address stall lengths set per test.
  logic [31:0] word_id, word_ts, junk;
  int          stall_cfg[2];
  int          stall_cnt[2];
  int          cyc;
  logic        pend_v[2];
  logic        pend_a[2];
  int          pend_cyc[2];

  function automatic int lat_of(int i);
    return (i == 0) ? 0 : L1;
  endfunction

  initial begin
    cyc = 0;
    junk = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      stall_cnt[i] = 0;
      pend_v[i]    = 1'b0;
      pend_a[i]    = 1'b0;
      pend_cyc[i]  = -1;
    end
  end

  always @(posedge clock) begin
    cyc  <= cyc + 1;
    junk <= $urandom;
    for (int i = 0; i < 2; i++) begin
      if (!avm_read[i]) begin
        stall_cnt[i] <= 0;
      end else if (avm_waitrequest[i]) begin
        stall_cnt[i] <= stall_cnt[i] + 1;
      end else begin
        stall_cnt[i] <= 0;
        pend_v[i]    <= 1'b1;
        pend_a[i]    <= avm_address[i];
        pend_cyc[i]  <= cyc + lat_of(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      avm_waitrequest[i] = 1'b0;
      avm_readdata[i]    = junk;
      avm_waitrequest[i] = avm_read[i] && (stall_cnt[i] < stall_cfg[avm_address[i]]);
      if (lat_of(i) == 0) begin
        if (avm_read[i] && !avm_waitrequest[i])
          avm_readdata[i] = avm_address[i] ? word_ts : word_id;
      end else if (pend_v[i] && (cyc == pend_cyc[i])) begin
        avm_readdata[i] = pend_a[i] ? word_ts : word_id;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          done_rel;
    logic        err;
    logic        id_ok;
    logic        ts_ok;
    logic [31:0] sysid;
    logic [31:0] tsv;
    int          rd_cycles;
    int          a1_cycles;
  } exp_t;

  // A check as a sequence of two reads: a read occupies (stall+1) strobe
  // cycles, or T cycles if the stall reaches T; data lands L cycles after
  // acceptance and the next phase starts one cycle after that.
  function automatic exp_t model(int L, int T, int s0, int s1,
                                 logic [31:0] idw, logic [31:0] tsw);
    exp_t e;
    int   ts_start;
    e.err = 1'b0; e.id_ok = 1'b0; e.ts_ok = 1'b0; e.sysid = '0; e.tsv = '0;
    if (s0 >= T) begin
      e.done_rel = 1 + T; e.err = 1'b1; e.rd_cycles = T; e.a1_cycles = 0;
    end else begin
      e.sysid  = idw;
      ts_start = 1 + s0 + L + 1;
      if (s1 >= T) begin
        e.done_rel = ts_start + T; e.err = 1'b1;
        e.rd_cycles = s0 + 1 + T; e.a1_cycles = T;
      end else begin
        e.done_rel  = ts_start + s1 + L + 1;
        e.tsv       = tsw;
        e.id_ok     = (idw == EXP_ID);
        e.ts_ok     = (tsw == EXP_TS);
        e.rd_cycles = s0 + s1 + 2;
        e.a1_cycles = s1 + 1;
      end
    end
    return e;
  endfunction

  task automatic run_check(input logic [31:0] idw, input logic [31:0] tsw,
                           input int s0, input int s1, input bit inject);
    exp_t        e[2];
    int          done_cnt[2], done_rel[2], rd_cnt[2], a1_cnt[2];
    logic        d_busy[2], d_err[2], d_id[2], d_ts[2];
    logic [31:0] d_sid[2], d_tsv[2];
    int          inj_rel;
    word_id = idw; word_ts = tsw; stall_cfg[0] = s0; stall_cfg[1] = s1;
    for (int i = 0; i < 2; i++) begin
      e[i] = model(lat_of(i), TMO, s0, s1, idw, tsw);
      done_cnt[i] = 0; done_rel[i] = -1; rd_cnt[i] = 0; a1_cnt[i] = 0;
      d_busy[i] = 1'b0; d_err[i] = 1'b0; d_id[i] = 1'b0; d_ts[i] = 1'b0;
      d_sid[i] = '0; d_tsv[i] = '0;
    end
    inj_rel = inject ? 1 + int'($urandom_range(0, 2)) : 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock);
    for (int rel = 1; rel <= WINDOW; rel++) begin
      start = (rel == inj_rel);
      for (int i = 0; i < 2; i++) begin
        if (avm_read[i]) rd_cnt[i]++;
        if (avm_read[i] && avm_address[i]) a1_cnt[i]++;
        if (done[i]) begin
          done_cnt[i]++; done_rel[i] = rel; d_busy[i] = busy[i];
          d_err[i] = error[i]; d_id[i] = id_ok[i]; d_ts[i] = ts_ok[i];
          d_sid[i] = sysid_value[i]; d_tsv[i] = timestamp_value[i];
        end
      end
      @(negedge clock);
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d done_count", i), done_cnt[i], 1);
      check($sformatf("dut%0d done_cycle", i), done_rel[i], e[i].done_rel);
      check($sformatf("dut%0d busy_in_done", i), d_busy[i], 1'b1);
      check($sformatf("dut%0d error", i), d_err[i], e[i].err);
      check($sformatf("dut%0d id_ok", i), d_id[i], e[i].id_ok);
      check($sformatf("dut%0d ts_ok", i), d_ts[i], e[i].ts_ok);
      check($sformatf("dut%0d sysid_value", i), d_sid[i], e[i].sysid);
      check($sformatf("dut%0d timestamp_value", i), d_tsv[i], e[i].tsv);
      check($sformatf("dut%0d read_cycles", i), rd_cnt[i], e[i].rd_cycles);
      check($sformatf("dut%0d addr1_cycles", i), a1_cnt[i], e[i].a1_cycles);
      check($sformatf("dut%0d idle_after", i), busy[i], 1'b0);
      check($sformatf("dut%0d hold_sysid", i), sysid_value[i], e[i].sysid);
      check($sformatf("dut%0d hold_ts", i), timestamp_value[i], e[i].tsv);
      check($sformatf("dut%0d hold_flags", i), {error[i], id_ok[i], ts_ok[i]},
            {e[i].err, e[i].id_ok, e[i].ts_ok});
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s dut%0d ctrl", tag, i),
            {busy[i], done[i], avm_read[i], avm_address[i], error[i], id_ok[i], ts_ok[i]}, '0);
      check($sformatf("%s dut%0d values", tag, i), sysid_value[i] | timestamp_value[i], '0);
    end
  endtask

  initial begin
    int extra_done;
    logic [31:0] idw, tsw;
    reset = 1'b1; start = 1'b0;
    word_id = EXP_ID; word_ts = EXP_TS; stall_cfg[0] = 0; stall_cfg[1] = 0;
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clock);

    run_check(EXP_ID, EXP_TS, 0, 0, 1'b0);
    run_check(32'h0000_0001, EXP_TS, 0, 0, 1'b0);
    run_check(EXP_ID, EXP_TS, 3, 0, 1'b0);
    run_check(EXP_ID, EXP_TS, 9, 0, 1'b0);
    run_check(EXP_ID, EXP_TS, 0, 9, 1'b0);
    run_check(EXP_ID, 32'h5600_0000, 3, 3, 1'b1);

    // Reset while instance 0 sits in RD_TS with the ID word already captured.
    word_id = 32'h1234_5678; word_ts = EXP_TS; stall_cfg[0] = 0; stall_cfg[1] = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    check_cleared("midreset");
    extra_done = 0;
    for (int c = 0; c < WINDOW; c++) begin
      if (done[0] || done[1]) extra_done++;
      @(negedge clock);
    end
    check("midreset no_done", extra_done, 0);

    for (int t = 0; t < 24; t++) begin
      idw = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      tsw = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      run_check(idw, tsw, $urandom_range(0, 5), $urandom_range(0, 5),
                bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
